// File: rtl/avalon_edge_pio_in_if.sv
// Avalon-MM slave bus bundle for the edge-capturing input PIO.
// The interconnect drives the master side and the PIO uses the slave side.
interface avalon_edge_pio_in_if;
   logic [1:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [31:0] readdata;

   modport master (
      output address,
      output chipselect,
      output write_n,
      output writedata,
      input  readdata
   );

   modport slave (
      input  address,
      input  chipselect,
      input  write_n,
      input  writedata,
      output readdata
   );
endinterface

// File: rtl/avalon_edge_pio_in.sv
// Avalon-MM input PIO: synchronise, debounce, per-bit edge select, W1C edge capture
// and a maskable interrupt.
module avalon_edge_pio_in #(
   parameter int WIDTH           = 8,
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 50000
) (
   input  logic                 clk,
   input  logic                 reset_n,
   avalon_edge_pio_in_if.slave  bus,
   input  logic [WIDTH-1:0]     in_port,
   output logic                 irq
);

   localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_r;
   logic [WIDTH-1:0]                  sync_s;
   logic [WIDTH-1:0][CNT_W-1:0]       cnt_r;
   logic [WIDTH-1:0][CNT_W-1:0]       cnt_next_s;
   logic [WIDTH-1:0]                  deb_r;
   logic [WIDTH-1:0]                  deb_next_s;
   logic [WIDTH-1:0]                  deb_prev_r;
   logic [WIDTH-1:0]                  qual_s;
   logic [2*WIDTH-1:0]                edge_mode_r;
   logic [WIDTH-1:0]                  irq_mask_r;
   logic [WIDTH-1:0]                  edge_cap_r;
   logic [WIDTH-1:0]                  w1c_s;
   logic [WIDTH-1:0]                  cap_next_s;
   logic [31:0]                       rd_s;
   logic [31:0]                       readdata_r;
   logic                              wr_s;
   logic                              unused_wd_s;

   assign sync_s      = sync_r[SYNC_STAGES-1];
   assign wr_s        = bus.chipselect & ~bus.write_n;
   assign unused_wd_s = ^bus.writedata;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync_r <= '0;
      end else begin
         sync_r <= {sync_r[SYNC_STAGES-2:0], in_port};
      end
   end

   // A pending change must hold for DEBOUNCE_CYCLES consecutive clocks; any return aborts it.
   always_comb begin
      deb_next_s = deb_r;
      cnt_next_s = cnt_r;
      for (int i = 0; i < WIDTH; i++) begin
         if (sync_s[i] == deb_r[i]) begin
            cnt_next_s[i] = '0;
         end else if (cnt_r[i] == CNT_TERM) begin
            deb_next_s[i] = sync_s[i];
            cnt_next_s[i] = '0;
         end else begin
            cnt_next_s[i] = cnt_r[i] + CNT_ONE;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_r      <= '0;
         deb_r      <= '0;
         deb_prev_r <= '0;
      end else begin
         cnt_r      <= cnt_next_s;
         deb_r      <= deb_next_s;
         deb_prev_r <= deb_r;
      end
   end

   // Qualify the debounced transition against the mode current while the new level is first visible.
   always_comb begin
      qual_s = '0;
      for (int i = 0; i < WIDTH; i++) begin
         qual_s[i] = (deb_r[i] & ~deb_prev_r[i] & edge_mode_r[2*i])
                   | (~deb_r[i] & deb_prev_r[i] & edge_mode_r[2*i+1]);
      end
   end

   always_comb begin
      w1c_s = '0;
      if (wr_s && (bus.address == 2'd3)) begin
         w1c_s = bus.writedata[WIDTH-1:0];
      end else begin
         w1c_s = '0;
      end
      cap_next_s = (edge_cap_r & ~w1c_s) | qual_s;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         edge_mode_r <= '0;
         irq_mask_r  <= '0;
         edge_cap_r  <= '0;
      end else begin
         edge_cap_r <= cap_next_s;
         if (wr_s && (bus.address == 2'd1)) begin
            edge_mode_r <= bus.writedata[2*WIDTH-1:0];
         end
         if (wr_s && (bus.address == 2'd2)) begin
            irq_mask_r <= bus.writedata[WIDTH-1:0];
         end
      end
   end

   always_comb begin
      rd_s = 32'd0;
      case (bus.address)
         2'd0:    rd_s[WIDTH-1:0]   = deb_r;
         2'd1:    rd_s[2*WIDTH-1:0] = edge_mode_r;
         2'd2:    rd_s[WIDTH-1:0]   = irq_mask_r;
         2'd3:    rd_s[WIDTH-1:0]   = edge_cap_r;
         default: rd_s              = 32'd0;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         readdata_r <= 32'd0;
      end else begin
         readdata_r <= rd_s;
      end
   end

   assign bus.readdata = readdata_r;
   assign irq          = |(edge_cap_r & irq_mask_r);

endmodule

// File: tb/tb_avalon_edge_pio_in.sv
// Randomised and directed bench for avalon_edge_pio_in, checked every cycle against
// a run-length behavioural model of the PIO.
module tb_avalon_edge_pio_in;

   localparam int WIDTH           = 8;
   localparam int SYNC_STAGES     = 2;
   localparam int DEBOUNCE_CYCLES = 4;

   logic             clk = 1'b0;
   logic             reset_n;
   logic [WIDTH-1:0] in_port;
   logic             irq;

   avalon_edge_pio_in_if bus ();

   avalon_edge_pio_in #(
      .WIDTH(WIDTH),
      .SYNC_STAGES(SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
   ) dut (
      .clk(clk),
      .reset_n(reset_n),
      .bus(bus),
      .in_port(in_port),
      .irq(irq)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model state
   logic [WIDTH-1:0]   m_hist [SYNC_STAGES];
   int                 m_run [WIDTH];
   logic [WIDTH-1:0]   m_run_val;
   logic [WIDTH-1:0]   m_deb;
   logic [WIDTH-1:0]   m_deb_prev;
   logic [2*WIDTH-1:0] m_mode;
   logic [WIDTH-1:0]   m_mask;
   logic [WIDTH-1:0]   m_cap;
   logic [31:0]        m_rd;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < SYNC_STAGES; k++) m_hist[k] = '0;
      for (int i = 0; i < WIDTH; i++) m_run[i] = 0;
      m_run_val  = '0;
      m_deb      = '0;
      m_deb_prev = '0;
      m_mode     = '0;
      m_mask     = '0;
      m_cap      = '0;
      m_rd       = 32'd0;
   endtask

   // Advance the model by one clock edge using the inputs present at that edge.
   task automatic model_step();
      logic [WIDTH-1:0] sync;
      logic [WIDTH-1:0] q;
      logic [WIDTH-1:0] w1c;
      logic [WIDTH-1:0] new_deb;
      logic [31:0]      new_rd;
      logic             wr;
      if (!reset_n) begin
         model_reset();
         return;
      end
      sync   = m_hist[SYNC_STAGES-1];
      wr     = bus.chipselect && !bus.write_n;
      new_rd = 32'd0;
      if (bus.address == 2'd0) new_rd = {24'd0, m_deb};
      if (bus.address == 2'd1) new_rd = {16'd0, m_mode};
      if (bus.address == 2'd2) new_rd = {24'd0, m_mask};
      if (bus.address == 2'd3) new_rd = {24'd0, m_cap};
      for (int i = 0; i < WIDTH; i++) begin
         q[i] = (m_deb[i] && !m_deb_prev[i] && m_mode[2*i])
             || (!m_deb[i] && m_deb_prev[i] && m_mode[2*i+1]);
      end
      w1c   = (wr && bus.address == 2'd3) ? bus.writedata[WIDTH-1:0] : '0;
      m_cap = (m_cap & ~w1c) | q;
      if (wr && bus.address == 2'd1) m_mode = bus.writedata[2*WIDTH-1:0];
      if (wr && bus.address == 2'd2) m_mask = bus.writedata[WIDTH-1:0];
      // deb takes a new level once sync has shown it for DEBOUNCE_CYCLES straight edges
      new_deb = m_deb;
      for (int i = 0; i < WIDTH; i++) begin
         if (sync[i] == m_run_val[i]) begin
            m_run[i]++;
         end else begin
            m_run_val[i] = sync[i];
            m_run[i]     = 1;
         end
         if (sync[i] != m_deb[i] && m_run[i] >= DEBOUNCE_CYCLES) new_deb[i] = sync[i];
      end
      m_deb_prev = m_deb;
      m_deb      = new_deb;
      for (int k = SYNC_STAGES - 1; k > 0; k--) m_hist[k] = m_hist[k-1];
      m_hist[0] = in_port;
      m_rd      = new_rd;
   endtask

   task automatic step();
      @(posedge clk);
      model_step();
      @(negedge clk);
      check("rd_model", bus.readdata, m_rd);
      check("irq_model", {31'd0, irq}, {31'd0, |(m_cap & m_mask)});
   endtask

   task automatic steps(input int n);
      for (int k = 0; k < n; k++) step();
   endtask

   task automatic bus_idle();
      bus.address    = 2'd0;
      bus.chipselect = 1'b0;
      bus.write_n    = 1'b1;
      bus.writedata  = 32'd0;
   endtask

   task automatic wr(input logic [1:0] a, input logic [31:0] d);
      bus.address    = a;
      bus.chipselect = 1'b1;
      bus.write_n    = 1'b0;
      bus.writedata  = d;
      step();
      bus_idle();
   endtask

   task automatic rd(input logic [1:0] a, output logic [31:0] v);
      bus.address    = a;
      bus.chipselect = 1'b1;
      bus.write_n    = 1'b1;
      step();
      v = bus.readdata;
      bus_idle();
   endtask

   initial begin
      logic [31:0] v;
      reset_n = 1'b0;
      in_port = '0;
      bus_idle();
      model_reset();
      steps(3);
      check("rst_readdata", bus.readdata, 32'd0);
      check("rst_irq", {31'd0, irq}, 32'd0);
      reset_n = 1'b1;
      steps(2);

      // 1: rising edge capture, irq exactly 7 edges after the change
      wr(2'd1, 32'h0000_0001);
      wr(2'd2, 32'h0000_0001);
      in_port[0] = 1'b1;
      for (int n = 1; n <= 9; n++) begin
         step();
         check("s1_irq_latency", {31'd0, irq}, (n >= 7) ? 32'd1 : 32'd0);
      end
      rd(2'd0, v);
      check("s1_data", v, 32'h0000_0001);
      rd(2'd3, v);
      check("s1_capture", v, 32'h0000_0001);

      // 2: a 3-clock glitch never reaches deb
      in_port[0] = 1'b0;
      steps(8);
      wr(2'd1, 32'h0000_000C);
      wr(2'd2, 32'h0000_00FF);
      wr(2'd3, 32'h0000_00FF);
      in_port[1] = 1'b1;
      steps(3);
      in_port[1] = 1'b0;
      for (int n = 0; n < 10; n++) begin
         step();
         check("s2_irq", {31'd0, irq}, 32'd0);
      end
      rd(2'd0, v);
      check("s2_data", v, 32'd0);
      rd(2'd3, v);
      check("s2_capture", v, 32'd0);

      // 3: both-edge mode with W1C between the edges
      wr(2'd1, 32'h0000_C000);
      in_port[7] = 1'b1;
      steps(10);
      rd(2'd3, v);
      check("s3_rise", v, 32'h0000_0080);
      wr(2'd3, 32'h0000_0080);
      rd(2'd3, v);
      check("s3_w1c", v, 32'd0);
      steps(7);
      in_port[7] = 1'b0;
      steps(9);
      rd(2'd3, v);
      check("s3_fall", v, 32'h0000_0080);

      // 4: W1C on the same edge as a falling capture on bit 2
      wr(2'd1, 32'h0000_0020);
      in_port[2] = 1'b1;
      steps(10);
      wr(2'd3, 32'h0000_00FF);
      in_port[2] = 1'b0;
      steps(6);
      wr(2'd3, 32'h0000_0004);
      rd(2'd3, v);
      check("s4_collision", v, 32'h0000_0004);

      // 5: mask gating of a captured bit
      wr(2'd2, 32'h0000_0000);
      wr(2'd1, 32'h0000_0100);
      wr(2'd3, 32'h0000_00FF);
      in_port[4] = 1'b1;
      steps(10);
      rd(2'd3, v);
      check("s5_capture", v, 32'h0000_0010);
      check("s5_irq_masked", {31'd0, irq}, 32'd0);
      wr(2'd2, 32'h0000_0010);
      check("s5_irq_unmasked", {31'd0, irq}, 32'd1);
      rd(2'd2, v);
      check("s5_mask_read", v, 32'h0000_0010);
      wr(2'd2, 32'h0000_0000);
      check("s5_irq_remasked", {31'd0, irq}, 32'd0);

      // 6: reset mid-debounce restarts from deb=0
      in_port = '0;
      steps(8);
      in_port[3] = 1'b1;
      steps(4);
      reset_n = 1'b0;
      model_reset();
      #1;
      check("s6_async_rd", bus.readdata, 32'd0);
      check("s6_async_irq", {31'd0, irq}, 32'd0);
      steps(2);
      reset_n = 1'b1;
      for (int a = 0; a < 4; a++) begin
         rd(2'(a), v);
         check("s6_regs_zero", v, 32'd0);
      end
      steps(2);
      rd(2'd0, v);
      check("s6_data_after", v, 32'h0000_0008);

      // Random traffic and inputs against the model
      for (int n = 0; n < 3000; n++) begin
         reset_n = ($urandom_range(0, 999) != 0);
         if (!reset_n) model_reset();
         for (int i = 0; i < WIDTH; i++) begin
            if ($urandom_range(0, 5) == 0) in_port[i] = ~in_port[i];
         end
         bus.address    = 2'($urandom_range(0, 3));
         bus.chipselect = ($urandom_range(0, 3) == 0);
         bus.write_n    = ($urandom_range(0, 1) == 0);
         bus.writedata  = $urandom;
         step();
      end
      reset_n = 1'b1;
      bus_idle();
      steps(2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
